// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared constants, field positions and FSM states for instruction fetch
//
// Purpose : datapath widths, instruction field bit positions (OpCode, P1, P2)
//           and the fetch FSM state type used by instr_fetch.
// Ports   : none (package).
package riscv_fetch_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    // Instruction field slices handed to the immediate generator.
    localparam int OPCODE_LSB = 2;
    localparam int OPCODE_MSB = 6;
    localparam int P1_LSB     = 20;
    localparam int P1_MSB     = 31;
    localparam int P2_LSB     = 7;
    localparam int P2_MSB     = 11;

    localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int P1_W     = P1_MSB - P1_LSB + 1;
    localparam int P2_W     = P2_MSB - P2_LSB + 1;

    localparam logic [XLEN-1:0] INSTR_BYTES = 64'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch stage with redirect and stall
//
// Purpose : holds the PC, requests one instruction word at a time from
//           instruction memory, registers it and presents it with its
//           decoded ImmGen fields until the consumer drops stall.
// Config  : FETCH_MISALIGN_CHECK_EN - when defined, a redirect whose target
//           is not word aligned parks the stage in ERR with misalign_err=1.
//           When undefined, redirect targets are forced word aligned and
//           misalign_err stays 0.
// Ports   :
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req, imem_addr           fetch request and address (= PC)
//   imem_ready, imem_rdata        response strobe and instruction word
//   stall                         hold the presented instruction
//   redirect, redirect_pc         PC change request and its target
//   inst_valid, pc, instr         presented instruction and its address
//   OpCode, InstructionP1/P2      instr[6:2], instr[31:20], instr[11:7]
//   misalign_err                  misaligned redirect target seen
module instr_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                inst_valid,
    output logic [XLEN-1:0]     pc,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] OpCode,
    output logic [P1_W-1:0]     InstructionP1,
    output logic [P2_W-1:0]     InstructionP2,
    output logic                misalign_err
);

    fetch_state_e         state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 inst_valid_q, inst_valid_d;
    logic                 misalign_err_q, misalign_err_d;

    logic [XLEN-1:0]      target;
    logic                 target_bad;

    // Redirect target conditioning.
    always_comb begin
        target = redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
        target_bad = (redirect_pc[1:0] != 2'b00);
`else
        target[1:0] = 2'b00;
        target_bad  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            inst_valid_q   <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            inst_valid_q   <= inst_valid_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        inst_valid_d   = inst_valid_q;
        misalign_err_d = misalign_err_q;

        if (redirect) begin
            // Redirect overrides everything: a response arriving in the same
            // cycle is dropped because instr_d is left untouched.
            pc_d           = target;
            inst_valid_d   = 1'b0;
            misalign_err_d = target_bad;
            state_d        = target_bad ? S_ERR : S_REQ;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_ready) begin
                        instr_d      = imem_rdata;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc_d         = pc_q + INSTR_BYTES;   // wraps naturally at 2^64
                        inst_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign imem_req      = (state_q == S_REQ);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign inst_valid    = inst_valid_q;
    assign misalign_err  = misalign_err_q;
    assign OpCode        = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign InstructionP1 = instr_q[P1_MSB:P1_LSB];
    assign InstructionP2 = instr_q[P2_MSB:P2_LSB];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL set the PC value loaded at reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  out  1  SHALL be the fetch request to instruction memory.
REQ-005 imem_addr  out  64  SHALL be the fetch address, equal to the current PC.
REQ-006 imem_ready  in  1  SHALL indicate that imem_rdata is valid for the current request.
REQ-007 imem_rdata  in  32  SHALL be the fetched instruction word.
REQ-008 stall  in  1  SHALL hold the presented instruction when high.
REQ-009 redirect  in  1  SHALL request a PC change (branch/jump).
REQ-010 redirect_pc  in  64  SHALL be the redirect target.
REQ-011 inst_valid  out  1  SHALL mark pc, instr and the decoded fields as valid.
REQ-012 pc  out  64  SHALL be the address of the presented instruction.
REQ-013 instr  out  32  SHALL be the registered instruction word.
REQ-014 OpCode  out  5  SHALL be instr[6:2], feeding ImmGen.
REQ-015 InstructionP1  out  12  SHALL be instr[31:20], feeding ImmGen.
REQ-016 InstructionP2  out  5  SHALL be instr[11:7], feeding ImmGen.
REQ-017 misalign_err  out  1  SHALL flag a misaligned redirect target.

Function
REQ-018 FSM states SHALL be IDLE, REQ, HOLD and ERR.
REQ-019 IDLE: outputs quiet for one cycle, then go to REQ.
REQ-020 REQ: imem_req=1 with imem_addr=PC, held stable until imem_ready; on imem_ready, register instr and fields, go to HOLD.
REQ-021 Latency: inst_valid SHALL rise the cycle after imem_ready is sampled high.
REQ-022 HOLD: inst_valid=1 with outputs stable while stall=1; on stall=0, PC<=PC+4 (mod 2^64, wraps to 0), go to REQ.
REQ-023 redirect SHALL have highest priority in every state: PC<=redirect_pc, inst_valid<=0, any in-flight imem_ready in that cycle dropped, next state REQ.
REQ-024 redirect and stall high together: redirect wins; stall ignored.
REQ-025 redirect and imem_ready high together: imem_rdata discarded, not presented.
REQ-026 imem_req SHALL be 0 in IDLE, HOLD and ERR.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, PC=RESET_PC, instr=0, all fields 0, inst_valid=0, imem_req=0, misalign_err=0.
REQ-028 Reset asserted mid-request SHALL abandon the request; no response is presented after release.

Configuration
REQ-029 With FETCH_MISALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL go to ERR, set misalign_err=1, and issue no requests; only an aligned redirect or reset leaves ERR.
REQ-030 Without FETCH_MISALIGN_CHECK_EN: redirect_pc[1:0] forced to 0, ERR unreachable, misalign_err tied 0 (port still present).

Structure
REQ-031 Shared package riscv_fetch_pkg SHALL hold XLEN=64, INSTR_W=32, the FSM state enum and field bit-position constants (OPCODE, P1, P2 slices).
REQ-032 No sub-module; the PC register, FSM and field slicing SHALL be inline.

Verification
REQ-033 Reset release with RESET_PC=0, imem_ready=1 every cycle -> imem_addr 0,4,8; inst_valid one cycle after each ready; PC steps by 4.
REQ-034 imem_rdata=32'hFFD00013 -> OpCode=5'b00100, InstructionP1=12'hFFD, InstructionP2=5'b00000, matching the ImmGen bench input.
REQ-035 stall=1 for 3 cycles in HOLD -> pc, instr and inst_valid unchanged; no imem_req; PC+4 on the cycle stall drops.
REQ-036 redirect=1, redirect_pc=64'h100 coincident with imem_ready -> data dropped; next imem_addr=64'h100; inst_valid=0 in between.
REQ-037 PC=64'hFFFF_FFFF_FFFF_FFFC, advance -> next imem_addr=0.
REQ-038 FETCH_MISALIGN_CHECK_EN defined, redirect_pc=64'h102 -> misalign_err=1, imem_req=0; then redirect_pc=64'h200 -> misalign_err=0, fetch at 64'h200.
